// File: rtl/fpu_add_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_add_arbiter
// Two-requester round-robin front end for a shared combinational FP adder.
// A granted request's operands are latched and presented to the adder. One
// cycle later the sum and NaN flag are captured and held as a response until
// it is accepted.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid[1:0]      per-requester request
//   req_ready[1:0]      per-requester accept strobe (combinational)
//   req{0,1}_{a,b}      IEEE-754 single operands per requester
//   add_a, add_b        operands to the external adder (from operand regs)
//   add_result, add_nan adder sum and NaN flag
//   rsp_valid/ready     response handshake
//   rsp_data/nan/id     captured sum, NaN flag, requester index
//   busy                high whenever not IDLE
//   nan_count           saturating count of NaN results
// ---------------------------------------------------------------------------
module fpu_add_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_result,
    input  logic             add_nan,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_nan,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] nan_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [31:0]      op_a_reg;
    logic [31:0]      op_b_reg;
    logic [31:0]      rsp_data_reg;
    logic             rsp_nan_reg;
    logic             rsp_id_reg;
    logic             last_grant_reg;
    logic [CNT_W-1:0] nan_count_reg;

    logic             grant_id;
    logic             ready_en;
    logic             req_hs;
    logic             rsp_hs;

    // A lone requester always wins; on a tie the one not served last wins.
    assign grant_id = (&req_valid) ? ~last_grant_reg : req_valid[1];

    // Ready is suppressed while reset is asserted so nothing is offered
    // during reset cycles even though the state register reads IDLE.
    assign ready_en = (state_reg == IDLE) && !rst;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign req_ready[gi] = ready_en && req_valid[gi] && (grant_id == 1'(gi));
    end

    assign req_hs = |(req_valid & req_ready);
    assign rsp_hs = rsp_valid && rsp_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_hs) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            rsp_data_reg   <= '0;
            rsp_nan_reg    <= 1'b0;
            rsp_id_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
            nan_count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (req_hs) begin
                op_a_reg       <= grant_id ? req1_a : req0_a;
                op_b_reg       <= grant_id ? req1_b : req0_b;
                rsp_id_reg     <= grant_id;
                last_grant_reg <= grant_id;
            end
            if (state_reg == EXEC) begin
                rsp_data_reg <= add_result;
                rsp_nan_reg  <= add_nan;
                if (add_nan && (nan_count_reg != {CNT_W{1'b1}})) begin
                    nan_count_reg <= nan_count_reg + CNT_W'(1);
                end
            end
        end
    end

    assign add_a     = op_a_reg;
    assign add_b     = op_b_reg;
    assign rsp_valid = (state_reg == RESP) && !rst;
    assign rsp_data  = rsp_data_reg;
    assign rsp_nan   = rsp_nan_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = (state_reg != IDLE);
    assign nan_count = nan_count_reg;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_add_arbiter
// Directed bench for fpu_add_arbiter (CNT_W=2 so saturation is reachable).
// A small table-driven adder stub answers the DUT's add_a/add_b; every
// expected value checked below is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_fpu_add_arbiter;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    logic [31:0]   add_a, add_b;
    logic [31:0]   add_result;
    logic          add_nan;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_nan;
    logic          rsp_id;
    logic          busy;
    logic [CW-1:0] nan_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_add_arbiter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .add_nan    (add_nan),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_nan    (rsp_nan),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .nan_count  (nan_count)
    );

    // Adder stub: only the operand pairs used below are known.
    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    always_comb begin
        add_nan    = is_nan(add_a) || is_nan(add_b);
        add_result = 32'h0000_0000;
        if (add_nan)
            add_result = 32'h7FC0_0000;
        else if (add_a == 32'h3F80_0000 && add_b == 32'h3F80_0000)
            add_result = 32'h4000_0000;
        else if (add_a == 32'h3F80_0000 && add_b == 32'h4000_0000)
            add_result = 32'h4040_0000;
        else if (add_a == 32'h4040_0000 && add_b == 32'h4040_0000)
            add_result = 32'h40C0_0000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        req0_a    = 32'h3F80_0000;
        req0_b    = 32'h3F80_0000;
        req1_a    = 32'h4040_0000;
        req1_b    = 32'h4040_0000;

        // Reset state
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_nan_count", 32'(nan_count), 32'h0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);

        // Single op from requester 0
        rst       = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();                             // handshake edge -> EXEC
        req_valid = 2'b00;
        chk("single_exec_busy", 32'(busy), 32'h1);
        chk("single_exec_ready", 32'(req_ready), 32'h0);
        chk("single_exec_rspv", 32'(rsp_valid), 32'h0);
        chk("single_add_a", add_a, 32'h3F80_0000);
        tick();                             // N+2 -> RESP
        chk("single_rspv", 32'(rsp_valid), 32'h1);
        chk("single_data", rsp_data, 32'h4000_0000);
        chk("single_id", 32'(rsp_id), 32'h0);
        chk("single_nan", 32'(rsp_nan), 32'h0);
        tick();
        chk("single_done_rspv", 32'(rsp_valid), 32'h0);
        chk("single_done_busy", 32'(busy), 32'h0);

        // Tie after reset: re-reset so last_grant is back to 1
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req0_a    = 32'h3F80_0000;
        req0_b    = 32'h4000_0000;
        req_valid = 2'b11;
        #1;
        chk("tie1_ready", 32'(req_ready), 32'h1);
        tick();
        tick();
        chk("tie1_data", rsp_data, 32'h4040_0000);
        chk("tie1_id", 32'(rsp_id), 32'h0);
        tick();
        chk("tie2_ready", 32'(req_ready), 32'h2);
        tick();
        tick();
        chk("tie2_data", rsp_data, 32'h40C0_0000);
        chk("tie2_id", 32'(rsp_id), 32'h1);
        tick();
        chk("tie3_ready", 32'(req_ready), 32'h1);

        // NaN ops from requester 1; counter saturates at 3 with CNT_W=2
        req1_a    = 32'h7FC0_0000;
        req1_b    = 32'h3F80_0000;
        req_valid = 2'b10;
        #1;
        chk("nan_ready", 32'(req_ready), 32'h2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            tick();
            chk($sformatf("nan%0d_flag", k), 32'(rsp_nan), 32'h1);
            chk($sformatf("nan%0d_id", k), 32'(rsp_id), 32'h1);
            chk($sformatf("nan%0d_count", k), 32'(nan_count), 32'((k > 3) ? 3 : k));
            tick();
        end
        req_valid = 2'b00;

        // Backpressure: response held 5 cycles while req0 stays valid
        req0_a    = 32'h3F80_0000;
        req0_b    = 32'h3F80_0000;
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_rspv", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d_data", k), rsp_data, 32'h4000_0000);
            chk($sformatf("bp%0d_id", k), 32'(rsp_id), 32'h0);
            chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
            if (k < 4) tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_ready", 32'(req_ready), 32'h0);
        tick();
        chk("bp_regrant", 32'(req_ready), 32'h1);
        chk("bp_idle_busy", 32'(busy), 32'h0);
        tick();                             // granted again -> EXEC
        chk("mid_exec_busy", 32'(busy), 32'h1);

        // Reset in EXEC aborts the op
        rst       = 1'b1;
        req_valid = 2'b00;
        tick();
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_rspv", 32'(rsp_valid), 32'h0);
        chk("abort_count", 32'(nan_count), 32'h0);
        rst = 1'b0;
        tick();
        chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
        req_valid = 2'b11;
        #1;
        chk("abort_tie_ready", 32'(req_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_add_arbiter.md
FPU_ADD_ARBITER -- requirements
Module: fpu_add_arbiter

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the NaN-result counter.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid  input  2  per-requester operation request (bit 0 = requester 0).
REQ-005 SHALL have ports: req_ready  output  2  per-requester accept strobe.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  32 each  IEEE-754 single operands per requester.
REQ-007 SHALL have ports: add_a, add_b  output  32 each  operands driven to the shared combinational FP adder.
REQ-008 SHALL have ports: add_result  input  32  adder sum; add_nan  input  1  adder NaN flag.
REQ-009 SHALL have ports: rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  32; rsp_nan  output  1; rsp_id  output  1 (requester index).
REQ-010 SHALL have ports: busy  output  1  high in any state other than IDLE; nan_count  output  CNT_W  saturating count of NaN results.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-012 IDLE: grant SHALL go to the only valid requester; if both are valid, to the requester not granted last (round-robin).
REQ-013 req_ready SHALL be combinational, high only in IDLE, only for the granted requester, and only while its req_valid is high.
REQ-014 On a handshake (valid & ready), SHALL latch that requester's A/B into operand registers, record the id, update last_grant, and go to EXEC.
REQ-015 add_a/add_b SHALL be driven from the operand registers at all times.
REQ-016 EXEC: SHALL last exactly one cycle, capturing add_result into rsp_data and add_nan into rsp_nan at its end, then go to RESP.
REQ-017 RESP: rsp_valid SHALL be high; rsp_data, rsp_nan and rsp_id SHALL stay stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-018 Latency: a handshake at cycle N SHALL give rsp_valid at cycle N+2; with rsp_ready held high, the next grant can occur at N+3.
REQ-019 No new request SHALL be accepted outside IDLE; req_ready SHALL be 0 in EXEC and RESP.
REQ-020 nan_count SHALL increment by 1 at the EXEC capture when add_nan=1, and SHALL saturate at all-ones with no wrap.
REQ-021 A requester dropping req_valid before its grant SHALL have no effect; a request present is not required to be held.
REQ-022 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-023 When rst is high at a clock edge, the block SHALL enter IDLE and clear all registers: operand regs, rsp_data, rsp_nan, rsp_id and nan_count to 0; last_grant to 1, so requester 0 wins the first tie.
REQ-024 During reset cycles, req_ready and rsp_valid SHALL be 0.
REQ-025 Reset in EXEC or RESP SHALL abort the transaction with no response issued.

Verification
REQ-026 Single op: req0 0x3F800000 + 0x3F800000, rsp_ready=1 -> rsp_valid 2 cycles after handshake, rsp_data=0x40000000, rsp_id=0, rsp_nan=0.
REQ-027 Tie after reset: both requesters valid (req0 1.0+2.0, req1 0x40400000+0x40400000), held -> responses in order id0 0x40400000, then id1 0x40C00000; a second tie grants id0 again.
REQ-028 NaN: req1 A=0x7FC00000, B=0x3F800000 -> rsp_nan=1, rsp_id=1, nan_count 0->1; with CNT_W=2, four NaN ops leave nan_count=3.
REQ-029 Backpressure: rsp_ready low 5 cycles in RESP, req0 valid throughout -> rsp_data/rsp_id stable, req_ready=0 throughout; grant occurs one cycle after the rsp_ready handshake.
REQ-030 Reset mid-op: rst pulsed in EXEC -> no rsp_valid, busy=0, nan_count=0, and the next tie grants requester 0.
